piso_shift_register: RTL

//   Parallel-in / serial-out transmitter. Partner to the team's parallel

---
 rtl/piso_shift_register.sv | 100 ++++++++++
 1 files changed

// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in / serial-out transmitter with valid/ready load and framing flags
// Words are loaded over in_valid/in_ready and shifted out one bit per shift_en cycle.
module piso_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             load;
  logic             advance;
  logic             last_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new word may load on the same edge that consumes the last bit, so a
  // held in_valid produces back-to-back frames with no idle cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    last_take  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt == LAST_IDX) begin
            last_take = 1'b1;
            in_ready  = !reset;
            if (in_valid) load = 1'b1;
            else          state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_take;
      if (load) begin
        shreg <= in_data;
        cnt   <= '0;
      end else if (advance) begin
        cnt   <= cnt + CW'(1);
        shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
      end else if (last_take) begin
        cnt <= '0;
      end
    end
  end

  // The outgoing bit always sits at the end of the register nearest the line.
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = ser_valid && (cnt == LAST_IDX);
  assign done      = done_q;

endmodule
